multi_asset_arb_engine: RTL and testbench
=========================================

# multi_asset_arb_engine

Parametrised multi-asset trading engine that replaces the fixed BTC/ETH trading core behind the network interface. It consumes a stream of tagged price updates for `NUM_ASSETS` instruments and keeps a per-asset baseline price and cooldown timer. It issues buy/sell orders through a buffered valid/ready order port whenever a move exceeds a threshold. It also reports executed/dropped trade counts and per-order tick-to-trade latency. It sits in the `clk_core` domain, between the network interface's decoded price output and its order-transmit input.

## Interface
- `NUM_ASSETS`, 4: number of tracked instruments (≥1)
- `PRICE_W`, 64: price width, unsigned
- `THRESH`, 64'd100: trigger when |price − baseline| ≥ THRESH
- `COOLDOWN`, 16: cycles an asset is blocked after it triggers
- `ORDER_DEPTH`, 8: order FIFO depth (power of 2, ≥2)
- `ID_W`, derived: max(1, $clog2(NUM_ASSETS))

- `clk_core` in 1: core clock, all logic on rising edge
- `rst` in 1: synchronous reset, active-high
- `price_valid` in 1: price update strobe, one update per cycle max
- `price_asset_id` in ID_W: instrument index
- `price_data` in PRICE_W: new price
- `order_valid` out 1: order available
- `order_ready` in 1: consumer accepts the order when it is high and `order_valid` is high
- `order_asset_id` out ID_W: instrument of head order
- `order_side` out 1: 0 = BUY (price fell), 1 = SELL (price rose)
- `order_price` out PRICE_W: price that triggered the order
- `order_latency` out 32: cycles from that order's input sample to its handshake, valid with handshake
- `trades_executed` out 32: completed handshakes, saturating
- `trades_dropped` out 32: triggers lost to a full FIFO, saturating
- `engine_active` out 1: stage-1 valid or FIFO non-empty

## Operation
- Per asset: `base[i]` (PRICE_W), `seen[i]`, and `cool[i]` (down-counter, $clog2(COOLDOWN+1) bits).
- Free-running 32-bit `tick` counter, wraps mod 2^32. Latency = `tick_now − tick_sample` mod 2^32.
- Stage 0 (input register): on `price_valid`, capture id, price and `tick`. An id ≥ NUM_ASSETS is discarded at capture.
- Stage 1 (evaluate, the cycle after capture):
  - `seen[id]=0`: write `base ← price`, set `seen`, no trigger.
  - Otherwise compute diff = |price − base| unsigned (no overflow; larger minus smaller). Side = SELL if price > base, else BUY.
  - Trigger = seen ∧ diff ≥ THRESH ∧ `cool[id]==0`.
  - On trigger: `base ← price`, `cool[id] ← COOLDOWN`, push {id, side, price, tick_sample} to the FIFO.
  - On a non-trigger (threshold not met or cooling): base unchanged.
- Every cycle, each nonzero `cool[i]` decrements by 1. A reload in the same cycle overrides the decrement.
- FIFO: show-ahead; head drives the `order_*` outputs.
  - Push succeeds if not full, or if full with a pop in the same cycle.
  - Otherwise the trigger is dropped and `trades_dropped` increments. The `base` and `cool` updates still apply.
- Handshake: `order_valid ∧ order_ready` pops the FIFO, increments `trades_executed`, and drives `order_latency`.
  - `order_latency` holds its last value between handshakes.
  - While `order_valid` is high and not accepted, all `order_*` fields stay stable.

## Timing
- All outputs reset to 0. On reset: FIFO empty, all `seen`/`cool` cleared, `tick` = 0, stage 0 invalid.
- Reset mid-operation discards in-flight and queued orders. No handshake completes in the reset cycle.
- Update sampled at edge E0; evaluated in the cycle after E0; pushed at edge E1. `order_valid` rises after E1 if the FIFO was empty. Minimum tick-to-order is 2 cycles.
- `order_latency` for an order accepted immediately equals 2.
- Back-to-back updates to the same asset are hazard-free. Stage 1 reads the table after the previous update's write at E1.
- A trigger and a COOLDOWN reload in cycle N block triggers for that asset in cycles N+1 … N+COOLDOWN.
- No combinational path from `order_ready` to `order_valid`.

## Configuration
- `ARB_KILL_SWITCH_EN` defined:
  - Adds input port `trade_halt` (1 bit).
  - While `trade_halt` is high in stage 1, triggers are suppressed: no push, no drop count, `base`/`cool` unchanged.
  - The FIFO continues draining normally.
- Undefined: no `trade_halt` port; behaviour is identical to `trade_halt` = 0.

## Test plan
- Reset, then asset 0 at 1000, then 1150, with `order_ready`=1 → order {id 0, SELL, 1150} exactly 2 cycles after the second update; `order_latency`=2; `trades_executed`=1.
- Asset 2 baseline 5000, then 4899 (diff 101) → BUY at 4899. Then 4850 within 16 cycles → no order. 4700 at cycle 17 after the trigger → BUY at 4700.
- `order_ready`=0, 10 triggering updates across assets (COOLDOWN satisfied) → 8 queued, `trades_dropped`=2. Release ready → 8 orders in order, fields stable while stalled, latencies increasing.
- Alternating assets 1 and 3 every cycle with diff exactly THRESH → every update after each baseline triggers. diff = THRESH−1 → none.
- `price_asset_id`=5 with NUM_ASSETS=5 → ignored, no state change. Reset asserted with 3 orders queued → `order_valid`=0 and counters = 0 the next cycle.
- With `ARB_KILL_SWITCH_EN`: `trade_halt`=1 during a 300-unit move → no order. Same price after halt drops → order issued.

Source files
------------

// File: rtl/multi_asset_arb_engine.sv
// multi_asset_arb_engine
//   Multi-instrument threshold trading core. Tagged price updates are
//   registered (stage 0), evaluated against a per-asset baseline and
//   cooldown timer (stage 1), and triggering moves are queued as orders in
//   a show-ahead FIFO that drives the order port.
//
// Optional feature macro: ARB_KILL_SWITCH_EN (adds trade_halt input).
//
// Ports
//   clk_core, rst            : core clock, synchronous active-high reset
//   trade_halt               : (ARB_KILL_SWITCH_EN only) suppress triggers
//   price_valid/asset_id/data: price update strobe, instrument, price
//   order_valid/ready        : order handshake
//   order_asset_id/side/price: head order fields (side 0=BUY, 1=SELL)
//   order_latency            : tick-to-trade of the last accepted order
//   trades_executed/dropped  : saturating handshake / overflow counters
//   engine_active            : stage 1 busy or orders queued
//
// Handshake: an order transfers on a rising edge where order_valid and
// order_ready are both high. order_valid never depends on order_ready in
// the same cycle, and while order_valid is high without acceptance the
// order_* fields hold steady.
module multi_asset_arb_engine #(
   parameter int                 NUM_ASSETS  = 4,
   parameter int                 PRICE_W     = 64,
   parameter logic [PRICE_W-1:0] THRESH      = PRICE_W'(100),
   parameter int                 COOLDOWN    = 16,
   parameter int                 ORDER_DEPTH = 8,
   localparam int                ID_W        = (NUM_ASSETS > 1) ? $clog2(NUM_ASSETS) : 1
) (
   input  logic               clk_core,
   input  logic               rst,
`ifdef ARB_KILL_SWITCH_EN
   input  logic               trade_halt,
`endif
   input  logic               price_valid,
   input  logic [ID_W-1:0]    price_asset_id,
   input  logic [PRICE_W-1:0] price_data,
   output logic               order_valid,
   input  logic               order_ready,
   output logic [ID_W-1:0]    order_asset_id,
   output logic               order_side,
   output logic [PRICE_W-1:0] order_price,
   output logic [31:0]        order_latency,
   output logic [31:0]        trades_executed,
   output logic [31:0]        trades_dropped,
   output logic               engine_active
);

   localparam int COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam int PTR_W  = $clog2(ORDER_DEPTH);
   localparam int ENT_W  = ID_W + 1 + PRICE_W + 32;

   logic               halt;
`ifdef ARB_KILL_SWITCH_EN
   assign halt = trade_halt;
`else
   assign halt = 1'b0;
`endif

   logic [31:0]        tick;

   // stage 0 registers
   logic               s0_valid;
   logic [ID_W-1:0]    s0_id;
   logic [PRICE_W-1:0] s0_price;
   logic [31:0]        s0_tick;

   // per-asset table
   logic [PRICE_W-1:0] base [NUM_ASSETS];
   logic [NUM_ASSETS-1:0] seen;
   logic [COOL_W-1:0]  cool [NUM_ASSETS];

   // order FIFO; entry = {id, side, price, sample tick}
   logic [ENT_W-1:0]   fifo_mem [ORDER_DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W:0]     count;
   logic [ENT_W-1:0]   head;

   // stage 1 evaluation
   logic [PRICE_W-1:0] cur_base;
   logic [PRICE_W-1:0] diff;
   logic               cur_seen;
   logic               side;
   logic               trigger;
   logic               full;
   logic               pop;
   logic               push;
   logic               drop;

   always_comb begin
      cur_base = base[s0_id];
      cur_seen = seen[s0_id];
      side     = (s0_price > cur_base);
      // larger minus smaller keeps the magnitude exact without a sign bit
      diff     = side ? (s0_price - cur_base) : (cur_base - s0_price);
      trigger  = s0_valid && cur_seen && (diff >= THRESH) &&
                 (cool[s0_id] == '0) && !halt;
      full     = (count == (PTR_W+1)'(ORDER_DEPTH));
      pop      = order_valid && order_ready;
      // a full FIFO still accepts when the head leaves in the same cycle
      push     = trigger && (!full || pop);
      drop     = trigger && !push;
   end

   always_ff @(posedge clk_core) begin
      if (rst) begin
         tick     <= '0;
         s0_valid <= 1'b0;
         s0_id    <= '0;
         s0_price <= '0;
         s0_tick  <= '0;
      end else begin
         tick     <= tick + 32'd1;
         // out-of-range ids never reach stage 1
         s0_valid <= price_valid && (32'(price_asset_id) < 32'(NUM_ASSETS));
         if (price_valid) begin
            s0_id    <= price_asset_id;
            s0_price <= price_data;
            s0_tick  <= tick;
         end
      end
   end

   always_ff @(posedge clk_core) begin
      if (rst) begin
         seen <= '0;
         for (int i = 0; i < NUM_ASSETS; i++) cool[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_ASSETS; i++)
            if (cool[i] != '0) cool[i] <= cool[i] - 1'b1;
         // the reload below is later in the block, so it wins over the decrement
         if (s0_valid) begin
            if (!cur_seen) begin
               base[s0_id] <= s0_price;
               seen[s0_id] <= 1'b1;
            end else if (trigger) begin
               base[s0_id] <= s0_price;
               cool[s0_id] <= COOL_W'(COOLDOWN);
            end
         end
      end
   end

   always_ff @(posedge clk_core) begin
      if (push) fifo_mem[wr_ptr] <= {s0_id, side, s0_price, s0_tick};
   end

   always_ff @(posedge clk_core) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_core) begin
      if (rst) begin
         order_latency   <= '0;
         trades_executed <= '0;
         trades_dropped  <= '0;
      end else begin
         if (pop) begin
            order_latency <= tick - head[31:0];
            if (trades_executed != '1) trades_executed <= trades_executed + 32'd1;
         end
         if (drop && trades_dropped != '1) trades_dropped <= trades_dropped + 32'd1;
      end
   end

   // head fields are gated so an empty FIFO presents all-zero outputs
   assign head           = fifo_mem[rd_ptr];
   assign order_valid    = (count != '0);
   assign order_asset_id = order_valid ? head[ENT_W-1 -: ID_W]     : '0;
   assign order_side     = order_valid ? head[32+PRICE_W]          : 1'b0;
   assign order_price    = order_valid ? head[32 +: PRICE_W]       : '0;
   assign engine_active  = s0_valid || order_valid;

endmodule

// File: tb/tb_multi_asset_arb_engine.sv
module tb_multi_asset_arb_engine;

   localparam int NA   = 5;
   localparam int ID_W = 3;

   logic              clk_core = 1'b0;
   logic              rst = 1'b1;
`ifdef ARB_KILL_SWITCH_EN
   logic              trade_halt = 1'b0;
`endif
   logic              price_valid = 1'b0;
   logic [ID_W-1:0]   price_asset_id = '0;
   logic [63:0]       price_data = '0;
   logic              order_valid;
   logic              order_ready = 1'b0;
   logic [ID_W-1:0]   order_asset_id;
   logic              order_side;
   logic [63:0]       order_price;
   logic [31:0]       order_latency;
   logic [31:0]       trades_executed;
   logic [31:0]       trades_dropped;
   logic              engine_active;

   multi_asset_arb_engine #(.NUM_ASSETS(NA)) dut (
      .clk_core        (clk_core),
      .rst             (rst),
`ifdef ARB_KILL_SWITCH_EN
      .trade_halt      (trade_halt),
`endif
      .price_valid     (price_valid),
      .price_asset_id  (price_asset_id),
      .price_data      (price_data),
      .order_valid     (order_valid),
      .order_ready     (order_ready),
      .order_asset_id  (order_asset_id),
      .order_side      (order_side),
      .order_price     (order_price),
      .order_latency   (order_latency),
      .trades_executed (trades_executed),
      .trades_dropped  (trades_dropped),
      .engine_active   (engine_active)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_core = ~clk_core;

   int cyc = 0;
   always @(posedge clk_core) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, got timeout, want finish");
      $fatal(1, "watchdog timeout");
   end

   // ---------------- scoreboard ----------------
   // entry = {id[2:0], side, price[63:0], sample cycle[31:0]}
   logic [99:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   logic [99:0] mon_e;
   logic [31:0] lat_exp;
   bit          lat_pending = 0;

   always @(negedge clk_core) begin
      if (rst) begin
         lat_pending = 0;
      end else begin
         if (lat_pending) begin
            check("order_latency", order_latency, lat_exp);
            lat_pending = 0;
         end
         if (order_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_order", order_valid, 1'b0);
            end else begin
               mon_e = exp_q[0];
               check("order_asset_id", order_asset_id, mon_e[99:97]);
               check("order_side", order_side, mon_e[96]);
               check("order_price", order_price, mon_e[95:32]);
               if (order_ready) begin
                  lat_exp     = 32'(cyc) - mon_e[31:0];
                  lat_pending = 1;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk_core);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) cycle();
   endtask

   task automatic send(input int id, input logic [63:0] price, input bit exp, input bit side);
      if (exp) exp_q.push_back({3'(id), side, price, 32'(cyc)});
      price_valid    = 1'b1;
      price_asset_id = 3'(id);
      price_data     = price;
      cycle();
      price_valid    = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle();
      check(tag, 32'(exp_q.size()), 32'd0);
      idle(2);
   endtask

   // ---------------- directed sequence ----------------
   logic [63:0] bases [NA];
   int          c0;
   int          k;
   logic [63:0] p;

   initial begin
      idle(3);
      rst = 1'b0;
      check("rst_order_valid", order_valid, 1'b0);
      check("rst_executed", trades_executed, 32'd0);
      check("rst_dropped", trades_dropped, 32'd0);
      check("rst_latency", order_latency, 32'd0);
      check("rst_active", engine_active, 1'b0);
      check("rst_price", order_price, 64'd0);

      // first trigger and its exact latency
      order_ready = 1'b1;
      send(0, 64'd1000, 0, 0);
      send(0, 64'd1150, 1, 1);
      check("t1_not_yet_valid", order_valid, 1'b0);
      check("t1_stage1_active", engine_active, 1'b1);
      cycle();
      check("t1_valid_after_2", order_valid, 1'b1);
      cycle();
      check("t1_latency", order_latency, 32'd2);
      check("t1_executed", trades_executed, 32'd1);
      check("t1_valid_cleared", order_valid, 1'b0);
      bases[0] = 64'd1150;

      // BUY trigger then cooldown window boundaries
      send(2, 64'd5000, 0, 0);
      c0 = cyc;
      send(2, 64'd4899, 1, 0);
      wait_until(c0 + 5);
      send(2, 64'd4850, 0, 0);
      wait_until(c0 + 16);
      send(2, 64'd4600, 0, 0);
      send(2, 64'd4700, 1, 0);
      drain("t2_drain");
      check("t2_executed", trades_executed, 32'd3);
      bases[2] = 64'd4700;

      // stall: 10 triggers into an 8-deep FIFO
      idle(20);
      send(1, 64'd2000, 0, 0); bases[1] = 64'd2000;
      send(3, 64'd3000, 0, 0); bases[3] = 64'd3000;
      send(4, 64'd4000, 0, 0); bases[4] = 64'd4000;
      order_ready = 1'b0;
      k = 0;
      for (int r = 0; r < 2; r++) begin
         for (int a = 0; a < NA; a++) begin
            p = bases[a] + 64'd200 + 64'($urandom_range(0, 50));
            bases[a] = p;
            send(a, p, (k < 8), 1);
            k++;
         end
         if (r == 0) idle(17);
      end
      idle(2);
      check("t3_dropped", trades_dropped, 32'd2);
      check("t3_still_valid", order_valid, 1'b1);
      check("t3_no_exec_stalled", trades_executed, 32'd3);
      order_ready = 1'b1;
      drain("t3_drain");
      check("t3_executed", trades_executed, 32'd11);

      // exactly THRESH triggers, THRESH-1 does not
      idle(17);
      send(1, bases[1] + 64'd100, 1, 1); bases[1] = bases[1] + 64'd100;
      send(3, bases[3] - 64'd100, 1, 0); bases[3] = bases[3] - 64'd100;
      idle(17);
      send(1, bases[1] - 64'd99, 0, 0);
      send(3, bases[3] + 64'd99, 0, 0);
      send(1, bases[1] - 64'd100, 1, 0); bases[1] = bases[1] - 64'd100;
      drain("t4_drain");
      check("t4_executed", trades_executed, 32'd14);

      // out-of-range ids are discarded
      send(5, 64'd100000, 0, 0);
      send(7, 64'd0, 0, 0);
      check("t5_bad_id_inactive", engine_active, 1'b0);
      send(0, bases[0] + 64'd100, 1, 1); bases[0] = bases[0] + 64'd100;
      drain("t5_drain");

      // reset with queued orders
      order_ready = 1'b0;
      send(2, bases[2] + 64'd300, 1, 1);
      send(3, bases[3] - 64'd300, 1, 0);
      send(4, bases[4] + 64'd300, 1, 1);
      idle(2);
      check("t6_queued_valid", order_valid, 1'b1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      exp_q.delete();
      check("t6_valid_cleared", order_valid, 1'b0);
      check("t6_exec_cleared", trades_executed, 32'd0);
      check("t6_drop_cleared", trades_dropped, 32'd0);
      check("t6_latency_cleared", order_latency, 32'd0);
      check("t6_active_cleared", engine_active, 1'b0);
      order_ready = 1'b1;
      send(0, 64'd500, 0, 0);
      send(0, 64'd700, 1, 1);
      drain("t6_drain");
      check("t6_executed", trades_executed, 32'd1);

`ifdef ARB_KILL_SWITCH_EN
      send(1, 64'd1000, 0, 0);
      trade_halt = 1'b1;
      send(1, 64'd1300, 0, 0);
      cycle();
      trade_halt = 1'b0;
      check("t7_halt_no_order", order_valid, 1'b0);
      check("t7_halt_no_drop", trades_dropped, 32'd0);
      send(1, 64'd1300, 1, 1);
      drain("t7_drain");
      check("t7_executed", trades_executed, 32'd2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
